// File: rtl/isa_pkg.sv
// ISA constants shared by the instruction encoder and its packing logic:
// format codes, opcodes, ALU ops, field offsets and the legality table.
package isa_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_JI  = 2'd2,
        FMT_JII = 2'd3
    } fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAD    = 2'd2,
        ST_DONE   = 2'd3
    } enc_state_t;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_J    = 5'd1;
    localparam logic [4:0] OP_BNE  = 5'd2;
    localparam logic [4:0] OP_JAL  = 5'd3;
    localparam logic [4:0] OP_JR   = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_BLT  = 5'd6;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] OP_SETX = 5'd21;
    localparam logic [4:0] OP_BEX  = 5'd22;

    localparam logic [4:0] ALU_MUL = 5'd6;
    localparam logic [4:0] ALU_DIV = 5'd7;

    localparam int OPCODE_LSB = 27;
    localparam int RD_LSB     = 22;
    localparam int RS_LSB     = 17;
    localparam int RT_LSB     = 12;
    localparam int SHAMT_LSB  = 7;
    localparam int ALUOP_LSB  = 2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Mirrors the control decoder's opcode -> format mapping.
    function automatic logic opcode_legal(input logic [1:0] fmt, input logic [4:0] opcode);
        logic ok;
        ok = 1'b0;
        case (fmt)
            FMT_R:   ok = (opcode == OP_ADD);
            FMT_I:   ok = (opcode == OP_BNE) || (opcode == OP_ADDI) || (opcode == OP_BLT) ||
                          (opcode == OP_SW)  || (opcode == OP_LW);
            FMT_JI:  ok = (opcode == OP_J)   || (opcode == OP_JAL) ||
                          (opcode == OP_SETX) || (opcode == OP_BEX);
            default: ok = (opcode == OP_JR);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds one 32-bit ISA word from decoded fields,
// zeroing fields the format does not use, and flags illegal combinations.
module instr_pack
    import isa_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [4:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  shamt,
    input  logic [4:0]  aluop,
    input  logic [16:0] imm,
    input  logic [26:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    logic [31:0] raw_word;
    logic        muldiv;

    always_comb begin
        raw_word = NOP_WORD;
        raw_word[OPCODE_LSB +: 5] = opcode;
        case (fmt)
            FMT_R: begin
                raw_word[RD_LSB +: 5]    = rd;
                raw_word[RS_LSB +: 5]    = rs;
                raw_word[RT_LSB +: 5]    = rt;
                raw_word[SHAMT_LSB +: 5] = shamt;
                raw_word[ALUOP_LSB +: 5] = aluop;
            end
            FMT_I: begin
                raw_word[RD_LSB +: 5] = rd;
                raw_word[RS_LSB +: 5] = rs;
                raw_word[16:0]        = imm;
            end
            FMT_JI: begin
                raw_word[26:0] = target;
            end
            default: begin
                raw_word[RD_LSB +: 5] = rd;
            end
        endcase
    end

    // mul/div exist only as R-type ALU operations
    assign muldiv  = (aluop == ALU_MUL) || (aluop == ALU_DIV);
    assign illegal = !opcode_legal(fmt, opcode) || ((fmt != FMT_R) && muldiv);
    assign word    = illegal ? NOP_WORD : raw_word;

endmodule

// File: rtl/instr_encoder.sv
// Session-based instruction encoder: accepts field records, packs them into ISA
// words, writes them sequentially into IMEM, then pads with NOPs to drain the pipe.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int PAD_NOPS = 4
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    input  logic [26:0]       in_target,
    input  logic              in_last,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_wrap
);

    localparam int PAD_W = (PAD_NOPS > 1) ? $clog2(PAD_NOPS) : 1;

    enc_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       fifo_word_reg [2];
    logic              fifo_last_reg [2];
    logic              wr_ptr_reg, rd_ptr_reg;
    logic [1:0]        count_reg;
    logic              last_seen_reg;
    logic [PAD_W-1:0]  pad_cnt_reg;
    logic              err_illegal_reg, err_wrap_reg, done_reg;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        start_ok, push, pop, pad_wr, head_last, pad_final;

    instr_pack u_pack (
        .fmt     (in_fmt),
        .opcode  (in_opcode),
        .rd      (in_rd),
        .rs      (in_rs),
        .rt      (in_rt),
        .shamt   (in_shamt),
        .aluop   (in_aluop),
        .imm     (in_imm),
        .target  (in_target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // Ready looks at plain full, so push+pop on a full FIFO never happens.
    assign start_ok  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign in_ready  = (state_reg == ST_ACTIVE) && (count_reg != 2'd2) && !last_seen_reg;
    assign push      = in_valid && in_ready;
    assign pop       = (state_reg == ST_ACTIVE) && (count_reg != 2'd0);
    assign pad_wr    = (state_reg == ST_PAD);
    assign head_last = fifo_last_reg[rd_ptr_reg];
    assign pad_final = (int'(pad_cnt_reg) == PAD_NOPS - 1);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (start) state_next = ST_ACTIVE;
            ST_ACTIVE: if (pop && head_last) state_next = (PAD_NOPS > 0) ? ST_PAD : ST_DONE;
            ST_PAD:    if (pad_final) state_next = ST_DONE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_wren = pop || pad_wr;
        imem_addr = addr_reg;
        imem_data = pop ? fifo_word_reg[rd_ptr_reg] : NOP_WORD;
        busy      = (state_reg == ST_ACTIVE) || (state_reg == ST_PAD);
        done      = done_reg;
    end

    assign err_illegal = err_illegal_reg;
    assign err_wrap    = err_wrap_reg;

    // FIFO payload carries no reset; occupancy is tracked by count_reg.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_word_reg[wr_ptr_reg] <= enc_word;
            fifo_last_reg[wr_ptr_reg] <= in_last;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_reg        <= '0;
            wr_ptr_reg      <= 1'b0;
            rd_ptr_reg      <= 1'b0;
            count_reg       <= 2'd0;
            last_seen_reg   <= 1'b0;
            pad_cnt_reg     <= '0;
            err_illegal_reg <= 1'b0;
            err_wrap_reg    <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= (state_next == ST_DONE) && (state_reg != ST_DONE);
            if (start_ok) begin
                addr_reg        <= base_addr;
                wr_ptr_reg      <= 1'b0;
                rd_ptr_reg      <= 1'b0;
                count_reg       <= 2'd0;
                last_seen_reg   <= 1'b0;
                pad_cnt_reg     <= '0;
                err_illegal_reg <= 1'b0;
                err_wrap_reg    <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= ~wr_ptr_reg;
                    if (enc_illegal) err_illegal_reg <= 1'b1;
                    if (in_last)     last_seen_reg   <= 1'b1;
                end
                if (pop) rd_ptr_reg <= ~rd_ptr_reg;
                count_reg <= count_reg + 2'(push) - 2'(pop);
                if (imem_wren) begin
                    addr_reg <= addr_reg + ADDR_W'(1);
                    if (&addr_reg) err_wrap_reg <= 1'b1;
                end
                if (pad_wr) pad_cnt_reg <= pad_cnt_reg + PAD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of field records with hand-packed
// words, applied in sessions, plus wrap, illegal and reset-mid-pad sequences.
module tb_instr_encoder;

    localparam int ADDR_W   = 12;
    localparam int PAD_NOPS = 4;

    typedef struct {
        logic [1:0]  fmt;
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  aluop;
        logic [16:0] imm;
        logic [26:0] target;
        logic [31:0] exp_word;
        logic        exp_ill;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_fmt = '0;
    logic [4:0]        in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0;
    logic [4:0]        in_shamt = '0, in_aluop = '0;
    logic [16:0]       in_imm = '0;
    logic [26:0]       in_target = '0;
    logic              in_last = 1'b0;
    logic              imem_wren;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              busy, done, err_illegal, err_wrap;

    always #5 clock = ~clock;

    instr_encoder #(.ADDR_W(ADDR_W), .PAD_NOPS(PAD_NOPS)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fmt      (in_fmt),
        .in_opcode   (in_opcode),
        .in_rd       (in_rd),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_shamt    (in_shamt),
        .in_aluop    (in_aluop),
        .in_imm      (in_imm),
        .in_target   (in_target),
        .in_last     (in_last),
        .imem_wren   (imem_wren),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal),
        .err_wrap    (err_wrap)
    );

    vec_t vecs [13];
    int   sel_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = -1;
    int   done_cyc = 0;

    logic [ADDR_W-1:0] log_addr [$];
    logic [31:0]       log_data [$];
    int                log_cyc  [$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (imem_wren) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_data);
            log_cyc.push_back(cyc);
            $display("[%0d] write addr=0x%03h data=0x%08h", cyc, imem_addr, imem_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_rec(input vec_t v, input logic last);
        int n = 0;
        in_fmt    = v.fmt;    in_opcode = v.opcode;
        in_rd     = v.rd;     in_rs     = v.rs;     in_rt = v.rt;
        in_shamt  = v.shamt;  in_aluop  = v.aluop;
        in_imm    = v.imm;    in_target = v.target;
        in_last   = last;     in_valid  = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        if (acc_cyc < 0) acc_cyc = cyc;
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic feed(input int s, input logic [ADDR_W-1:0] base, input bit gaps);
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        acc_cyc   = -1;
        start     = 1'b1;
        base_addr = base;
        @(negedge clock);
        start = 1'b0;
        check($sformatf("s%0d_start_busy", s), 32'(busy), 32'd1);
        check($sformatf("s%0d_start_err_illegal", s), 32'(err_illegal), 32'd0);
        check($sformatf("s%0d_start_err_wrap", s), 32'(err_wrap), 32'd0);
        for (int k = 0; k < sel_q.size(); k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
            if (gaps && k == 1) begin
                start     = 1'b1;
                base_addr = 12'h555;
                @(negedge clock);
                start = 1'b0;
            end
            push_rec(vecs[sel_q[k]], k == sel_q.size() - 1);
        end
        check($sformatf("s%0d_ready_after_last", s), 32'(in_ready), 32'd0);
    endtask

    task automatic verify(input int s, input logic [ADDR_W-1:0] base, input bit tight);
        int   n = sel_q.size();
        int   w = 0;
        logic exp_ill = 1'b0;
        logic exp_wrap;
        while (!done && w < 200) begin
            @(negedge clock);
            w++;
        end
        check($sformatf("s%0d_done", s), 32'(done), 32'd1);
        done_cyc = cyc;
        @(negedge clock);
        check($sformatf("s%0d_done_pulse", s), 32'(done), 32'd0);
        check($sformatf("s%0d_nwrites", s), 32'(log_addr.size()), 32'(n + PAD_NOPS));
        if (log_addr.size() == n + PAD_NOPS) begin
            for (int k = 0; k < n + PAD_NOPS; k++) begin
                logic [ADDR_W-1:0] ea;
                logic [31:0]       ed;
                ea = base + ADDR_W'(k);
                ed = (k < n) ? vecs[sel_q[k]].exp_word : 32'h0;
                check($sformatf("s%0d_addr%0d", s, k), 32'(log_addr[k]), 32'(ea));
                check($sformatf("s%0d_data%0d", s, k), log_data[k], ed);
                if (tight) check($sformatf("s%0d_cycle%0d", s, k), 32'(log_cyc[k]), 32'(log_cyc[0] + k));
            end
            check($sformatf("s%0d_latency", s), 32'(log_cyc[0]), 32'(acc_cyc + 1));
            check($sformatf("s%0d_done_cycle", s), 32'(done_cyc), 32'(log_cyc[n + PAD_NOPS - 1] + 1));
        end
        for (int k = 0; k < n; k++) exp_ill = exp_ill | vecs[sel_q[k]].exp_ill;
        exp_wrap = (int'(base) + n + PAD_NOPS) > (1 << ADDR_W);
        check($sformatf("s%0d_err_illegal", s), 32'(err_illegal), 32'(exp_ill));
        check($sformatf("s%0d_err_wrap", s), 32'(err_wrap), 32'(exp_wrap));
        check($sformatf("s%0d_idle_busy", s), 32'(busy), 32'd0);
        $display("session %0d base=0x%03h records=%0d checked", s, base, n);
    endtask

    initial begin
        //                fmt  op     rd     rs     rt     sh    alu   imm          target          word          ill
        vecs[0]  = '{2'd0, 5'd0,  5'd3,  5'd1,  5'd2,  5'd0, 5'd0, 17'd0,       27'd0,          32'h00C22000, 1'b0};
        vecs[1]  = '{2'd0, 5'd0,  5'd7,  5'd8,  5'd9,  5'd5, 5'd6, 17'd0,       27'd0,          32'h01D09298, 1'b0};
        vecs[2]  = '{2'd1, 5'd5,  5'd1,  5'd0,  5'd3,  5'd4, 5'd0, 17'd5,       27'h123,        32'h28400005, 1'b0};
        vecs[3]  = '{2'd2, 5'd1,  5'd5,  5'd0,  5'd0,  5'd0, 5'd0, 17'd0,       27'h100,        32'h08000100, 1'b0};
        vecs[4]  = '{2'd3, 5'd4,  5'd31, 5'd3,  5'd0,  5'd0, 5'd0, 17'h1ABCD,   27'd0,          32'h27C00000, 1'b0};
        vecs[5]  = '{2'd1, 5'd8,  5'd2,  5'd29, 5'd0,  5'd0, 5'd0, 17'h1FFFF,   27'd0,          32'h40BBFFFF, 1'b0};
        vecs[6]  = '{2'd2, 5'd22, 5'd0,  5'd0,  5'd0,  5'd0, 5'd0, 17'd0,       27'h7FFFFFF,    32'hB7FFFFFF, 1'b0};
        vecs[7]  = '{2'd2, 5'd3,  5'd0,  5'd0,  5'd0,  5'd0, 5'd0, 17'd0,       27'h0ABCDEF,    32'h18ABCDEF, 1'b0};
        vecs[8]  = '{2'd0, 5'd5,  5'd1,  5'd2,  5'd3,  5'd0, 5'd0, 17'd0,       27'd0,          32'h00000000, 1'b1};
        vecs[9]  = '{2'd1, 5'd0,  5'd1,  5'd2,  5'd0,  5'd0, 5'd0, 17'd5,       27'd0,          32'h00000000, 1'b1};
        vecs[10] = '{2'd1, 5'd2,  5'd1,  5'd2,  5'd0,  5'd0, 5'd7, 17'd5,       27'd0,          32'h00000000, 1'b1};
        vecs[11] = '{2'd3, 5'd1,  5'd4,  5'd0,  5'd0,  5'd0, 5'd0, 17'd0,       27'd0,          32'h00000000, 1'b1};
        vecs[12] = '{2'd2, 5'd21, 5'd0,  5'd0,  5'd0,  5'd0, 5'd0, 17'd0,       27'h42,         32'hA8000042, 1'b0};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("idle%0d_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("idle%0d_wren", i), 32'(imem_wren), 32'd0);
            check($sformatf("idle%0d_done", i), 32'(done), 32'd0);
            @(negedge clock);
        end
        check("reset_data", imem_data, 32'h0);
        check("reset_addr", 32'(imem_addr), 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_errs", 32'({err_illegal, err_wrap}), 32'd0);

        sel_q = {0};
        feed(1, 12'h010, 1'b0);
        verify(1, 12'h010, 1'b1);

        sel_q = {1, 2, 3, 4, 5, 6, 7, 12};
        feed(2, 12'h100, 1'b0);
        verify(2, 12'h100, 1'b1);

        sel_q = {8, 0, 9, 10, 11};
        feed(3, 12'h200, 1'b0);
        verify(3, 12'h200, 1'b1);

        sel_q = {2, 3, 4};
        feed(4, 12'hFFE, 1'b0);
        verify(4, 12'hFFE, 1'b1);

        // Gapped session with an ignored start, then reset while padding
        sel_q = {5, 1, 6};
        feed(5, 12'h300, 1'b1);
        begin
            int w = 0;
            while (log_addr.size() < 4 && w < 200) begin
                @(negedge clock);
                w++;
            end
        end
        check("s5_pad_reached", 32'(log_addr.size() >= 4), 32'd1);
        if (log_addr.size() >= 4) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("s5_addr%0d", k), 32'(log_addr[k]), 32'(12'h300 + k));
                check($sformatf("s5_data%0d", k), log_data[k], vecs[sel_q[k]].exp_word);
            end
            check("s5_nop_addr", 32'(log_addr[3]), 32'h303);
            check("s5_nop_data", log_data[3], 32'h0);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("post_reset%0d_wren", i), 32'(imem_wren), 32'd0);
            check($sformatf("post_reset%0d_busy", i), 32'(busy), 32'd0);
            @(negedge clock);
        end
        check("post_reset_done", 32'(done), 32'd0);
        check("post_reset_addr", 32'(imem_addr), 32'h0);
        check("post_reset_errs", 32'({err_illegal, err_wrap}), 32'd0);
        start     = 1'b1;
        base_addr = 12'h020;
        @(negedge clock);
        start = 1'b0;
        check("post_reset_start_ready", 32'(in_ready), 32'd1);
        check("post_reset_start_addr", 32'(imem_addr), 32'h020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
